// File: rtl/commit_trace_fifo.sv
// Commit trace buffer: captures retiring instructions with a running retire index
// and presents them first-word-fall-through to a trace consumer.
module commit_trace_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     commit_valid_i,
  input  logic [XLEN-1:0]          commit_pc_i,
  input  logic [31:0]              commit_instr_i,
  input  logic [4:0]               commit_rd_i,
  input  logic [XLEN-1:0]          commit_rd_data_i,
  input  logic                     flush_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic [4:0]               trace_rd_o,
  output logic [XLEN-1:0]          trace_rd_data_o,
  output logic [31:0]              trace_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = XLEN + 32 + 5 + XLEN + 32;

  // Handshake: a record transfers on any rising edge where trace_valid_o and
  // trace_ready_i are both high; the head fields hold steady until then.

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [31:0]      seq_q;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q;

  logic             pop, push, drop;
  logic [REC_W-1:0] head;

  assign trace_valid_o = (count_q != '0);
  assign pop  = trace_valid_o && trace_ready_i;
  // A full buffer still accepts a commit when the head leaves in the same cycle.
  assign push = commit_valid_i && ((count_q < CW'(DEPTH)) || pop);
  assign drop = commit_valid_i && !push;

  assign head = mem_q[rd_ptr_q];
  assign {trace_pc_o, trace_instr_o, trace_rd_o, trace_rd_data_o, trace_seq_o} = head;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

  // Storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push) begin
      mem_q[wr_ptr_q] <= {commit_pc_i, commit_instr_i, commit_rd_i, commit_rd_data_i, seq_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (commit_valid_i) begin
        seq_q <= seq_q + 32'd1;
      end
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
          count_q <= count_q + CW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CW'(1);
        end
        if (drop) begin
          overflow_q <= 1'b1;
          if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: directed scenarios followed by random traffic,
// all checked against a queue-based reference of the trace buffer.
module tb_commit_trace_fifo;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] seq;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cv = 1'b0;
  logic [XLEN-1:0]  c_pc = '0;
  logic [31:0]      c_instr = '0;
  logic [4:0]       c_rd = '0;
  logic [XLEN-1:0]  c_data = '0;
  logic             flush = 1'b0;
  logic             rdy = 1'b0;
  logic             t_valid;
  logic [XLEN-1:0]  t_pc;
  logic [31:0]      t_instr;
  logic [4:0]       t_rd;
  logic [XLEN-1:0]  t_data;
  logic [31:0]      t_seq;
  logic [4:0]       count;
  logic             ovf;
  logic [15:0]      drops;

  int errors = 0;
  int checks = 0;

  rec_t        m_q[$];
  logic [31:0] m_seq;
  logic        m_ovf;
  logic [15:0] m_drop;

  always #5 clk = ~clk;

  commit_trace_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(cv), .commit_pc_i(c_pc),
    .commit_instr_i(c_instr), .commit_rd_i(c_rd), .commit_rd_data_i(c_data),
    .flush_i(flush), .trace_valid_o(t_valid), .trace_ready_i(rdy),
    .trace_pc_o(t_pc), .trace_instr_o(t_instr), .trace_rd_o(t_rd),
    .trace_rd_data_o(t_data), .trace_seq_o(t_seq), .count_o(count),
    .overflow_o(ovf), .drop_cnt_o(drops)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("valid", 64'(t_valid), 64'(m_q.size() != 0));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("drop_cnt", 64'(drops), 64'(m_drop));
    if (m_q.size() != 0) begin
      chk("head_pc", 64'(t_pc), 64'(m_q[0].pc));
      chk("head_instr", 64'(t_instr), 64'(m_q[0].instr));
      chk("head_rd", 64'(t_rd), 64'(m_q[0].rd));
      chk("head_data", 64'(t_data), 64'(m_q[0].data));
      chk("head_seq", 64'(t_seq), 64'(m_q[0].seq));
    end
  endtask

  // Reference behaviour evaluated from the pre-edge inputs and buffer contents.
  task automatic model_edge();
    bit m_pop, m_push;
    rec_t r;
    if (rst) begin
      m_q.delete();
      m_seq = 0;
      m_ovf = 1'b0;
      m_drop = 16'h0;
      return;
    end
    if (flush) begin
      m_q.delete();
    end else begin
      m_pop  = (m_q.size() != 0) && rdy;
      m_push = cv && (m_q.size() < DEPTH || m_pop);
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        r = '{pc: c_pc, instr: c_instr, rd: c_rd, data: c_data, seq: m_seq};
        m_q.push_back(r);
      end else if (cv) begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    if (cv) m_seq = m_seq + 32'd1;
  endtask

  // Inputs are applied at a falling edge, outputs checked at the next one.
  task automatic cyc(input bit v, input bit r, input bit f, input bit rs, input bit do_chk);
    rst = rs; cv = v; rdy = r; flush = f;
    c_pc = $urandom; c_instr = $urandom; c_rd = 5'($urandom_range(0, 31)); c_data = $urandom;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (do_chk) check_model();
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    m_seq = 0; m_ovf = 1'b0; m_drop = 16'h0;
    @(negedge clk);
    cyc(0, 0, 0, 1, 1);
    chk("reset_valid", 64'(t_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_drops", 64'(drops), 64'd0);

    // Single commit with a known record.
    rst = 0; cv = 1; rdy = 0; flush = 0;
    c_pc = 32'h8000_0000; c_instr = 32'h0010_0093; c_rd = 5'd1; c_data = 32'd1;
    @(posedge clk); model_edge(); @(negedge clk); check_model();
    chk("single_valid", 64'(t_valid), 64'd1);
    chk("single_pc", 64'(t_pc), 64'h8000_0000);
    chk("single_instr", 64'(t_instr), 64'h0010_0093);
    chk("single_rd", 64'(t_rd), 64'd1);
    chk("single_data", 64'(t_data), 64'd1);
    chk("single_seq", 64'(t_seq), 64'd0);
    chk("single_count", 64'(count), 64'd1);
    cyc(0, 1, 0, 0, 1);
    chk("single_pop_count", 64'(count), 64'd0);

    // Fill with overflow, then drain in order.
    do_reset();
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, 0, 1);
    chk("fill_count", 64'(count), 64'd16);
    chk("fill_ovf", 64'(ovf), 64'd1);
    chk("fill_drops", 64'(drops), 64'd2);
    for (int i = 0; i < 16; i++) begin
      chk("drain_seq", 64'(t_seq), 64'(i));
      cyc(0, 1, 0, 0, 1);
    end
    chk("drain_empty", 64'(t_valid), 64'd0);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    chk("fullpp_count", 64'(count), 64'd16);
    chk("fullpp_drops", 64'(drops), 64'd0);
    chk("fullpp_tail_seq", 64'(m_q[15].seq), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk("fullpp_seq", 64'(t_seq), 64'(i + 1));
      cyc(0, 1, 0, 0, 1);
    end

    // Flush with a commit in the same cycle.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_drops", 64'(drops), 64'd0);
    cyc(1, 0, 0, 0, 1);
    chk("flush_next_seq", 64'(t_seq), 64'd6);

    // Mid-operation reset with a commit pending.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 1, 1);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_valid", 64'(t_valid), 64'd0);
    cyc(1, 0, 0, 0, 1);
    chk("midrst_seq", 64'(t_seq), 64'd0);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) cyc(1, 0, 0, 0, 0);
    check_model();
    chk("sat_drops", 64'(drops), 64'hFFFF);
    chk("sat_ovf", 64'(ovf), 64'd1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 40) == 0), bit'($urandom_range(0, 250) == 0), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
